// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: opcode-driven format select, XLEN-wide
// immediate, illegal flagging, and a valid/ready output with optional skid.
module imm_decode_stage #(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_immtype,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic            w_is_u;
  logic            w_is_i;
  logic            w_is_s;
  logic            w_is_sh;
  logic            w_is_b;
  logic            w_is_j;
  logic            w_is_csr;
  logic [31:0]     w_imm32;
  logic [2:0]      w_type;
  logic            w_ill;
  logic [XLEN-1:0] w_imm;

  assign w_op = in_instr[6:0];
  assign w_f3 = in_instr[14:12];

  assign w_is_u   = (w_op == OP_LUI) || (w_op == OP_AUIPC);
  assign w_is_sh  = (w_op == OP_OPIMM)
                 && ((w_f3 == 3'b001) || (w_f3 == 3'b101));
  assign w_is_i   = (w_op == OP_LOAD) || (w_op == OP_JALR)
                 || ((w_op == OP_OPIMM) && !w_is_sh);
  assign w_is_s   = (w_op == OP_STORE);
  assign w_is_b   = (w_op == OP_BRANCH);
  assign w_is_j   = (w_op == OP_JAL);
  assign w_is_csr = (w_op == OP_SYSTEM);

  always_comb begin
    w_imm32 = '0;
    w_type  = 3'b111;
    w_ill   = 1'b1;
    unique case (1'b1)
      w_is_u: begin
        w_imm32 = {in_instr[31:12], 12'b0};
        w_type  = 3'b000;
        w_ill   = 1'b0;
      end
      w_is_i: begin
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        w_type  = 3'b001;
        w_ill   = 1'b0;
      end
      w_is_s: begin
        w_imm32 = {{20{in_instr[31]}},
                   in_instr[31:25], in_instr[11:7]};
        w_type  = 3'b010;
        w_ill   = 1'b0;
      end
      w_is_sh: begin
        // RV32 has a 5-bit shamt; bit 25 set is reserved there
        w_imm32 = (XLEN == 64)
                ? {26'b0, in_instr[25:20]}
                : {27'b0, in_instr[24:20]};
        w_type  = 3'b011;
        w_ill   = (XLEN == 32) && in_instr[25];
      end
      w_is_b: begin
        w_imm32 = {{19{in_instr[31]}}, in_instr[31],
                   in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
        w_type  = 3'b100;
        w_ill   = 1'b0;
      end
      w_is_j: begin
        w_imm32 = {{11{in_instr[31]}}, in_instr[31],
                   in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
        w_type  = 3'b101;
        w_ill   = 1'b0;
      end
      w_is_csr: begin
        w_imm32 = {27'b0, in_instr[19:15]};
        w_type  = 3'b110;
        w_ill   = 1'b0;
      end
      default: ;
    endcase
    if (in_instr[1:0] != 2'b11) w_ill = 1'b1;
  end

  // zero-extended forms have bit 31 clear, so one sign-extend covers all
  assign w_imm = XLEN'($signed(w_imm32));

  logic            r_valid;
  logic [XLEN-1:0] r_imm;
  logic [2:0]      r_type;
  logic            r_ill;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;

  logic            r_s_valid;
  logic [XLEN-1:0] r_s_imm;
  logic [2:0]      r_s_type;
  logic            r_s_ill;
  logic [XLEN-1:0] r_s_pc;
  logic [31:0]     r_s_instr;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_load;

  assign w_out_fire  = r_valid && out_ready;
  assign w_main_load = !r_valid || w_out_fire;
  assign in_ready    = SKID ? !r_s_valid : w_main_load;
  assign w_in_fire   = in_valid && in_ready && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_imm     <= '0;
      r_type    <= '0;
      r_ill     <= 1'b0;
      r_pc      <= '0;
      r_instr   <= '0;
      r_s_valid <= 1'b0;
      r_s_imm   <= '0;
      r_s_type  <= '0;
      r_s_ill   <= 1'b0;
      r_s_pc    <= '0;
      r_s_instr <= '0;
    end else if (w_main_load) begin
      if (r_s_valid) begin
        r_valid   <= 1'b1;
        r_imm     <= r_s_imm;
        r_type    <= r_s_type;
        r_ill     <= r_s_ill;
        r_pc      <= r_s_pc;
        r_instr   <= r_s_instr;
        r_s_valid <= 1'b0;
      end else begin
        r_valid <= w_in_fire;
        if (w_in_fire) begin
          r_imm   <= w_imm;
          r_type  <= w_type;
          r_ill   <= w_ill;
          r_pc    <= in_pc;
          r_instr <= in_instr;
        end
      end
    end else if (SKID && w_in_fire) begin
      r_s_valid <= 1'b1;
      r_s_imm   <= w_imm;
      r_s_type  <= w_type;
      r_s_ill   <= w_ill;
      r_s_pc    <= in_pc;
      r_s_instr <= in_instr;
    end
  end

  assign out_valid   = r_valid;
  assign out_imm     = r_imm;
  assign out_immtype = r_type;
  assign out_illegal = r_ill;
  assign out_pc      = r_pc;
  assign out_instr   = r_instr;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: RV32/RV64 skid builds and an RV32 no-skid build
// checked against a FIFO-plus-decode reference model.
module tb_imm_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic [31:0] imm0, imm2;
  logic [63:0] imm1;
  logic [2:0]  t0, t1, t2;
  logic        il0, il1, il2;
  logic [31:0] pc0, pc2;
  logic [63:0] pc1;
  logic [31:0] ins0, ins1, ins2;

  imm_decode_stage #(.XLEN(32), .SKID(1'b1)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(ov0),
    .out_ready(out_ready), .out_imm(imm0), .out_immtype(t0),
    .out_illegal(il0), .out_pc(pc0), .out_instr(ins0));

  imm_decode_stage #(.XLEN(64), .SKID(1'b1)) u_d64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov1),
    .out_ready(out_ready), .out_imm(imm1), .out_immtype(t1),
    .out_illegal(il1), .out_pc(pc1), .out_instr(ins1));

  imm_decode_stage #(.XLEN(32), .SKID(1'b0)) u_n32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(ov2),
    .out_ready(out_ready), .out_imm(imm2), .out_immtype(t2),
    .out_illegal(il2), .out_pc(pc2), .out_instr(ins2));

  logic        a_ir [3];
  logic        a_ov [3];
  logic [63:0] a_imm [3];
  logic [2:0]  a_t [3];
  logic        a_il [3];
  logic [63:0] a_pc [3];
  logic [31:0] a_ins [3];

  always_comb begin
    a_ir[0] = ir0;  a_ir[1] = ir1;  a_ir[2] = ir2;
    a_ov[0] = ov0;  a_ov[1] = ov1;  a_ov[2] = ov2;
    a_imm[0] = 64'(imm0); a_imm[1] = imm1; a_imm[2] = 64'(imm2);
    a_t[0] = t0;    a_t[1] = t1;    a_t[2] = t2;
    a_il[0] = il0;  a_il[1] = il1;  a_il[2] = il2;
    a_pc[0] = 64'(pc0); a_pc[1] = pc1; a_pc[2] = 64'(pc2);
    a_ins[0] = ins0; a_ins[1] = ins1; a_ins[2] = ins2;
  end

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } item_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  item_t mq [3][2];
  int    mcnt [3];
  int    xl [3] = '{32, 64, 32};
  bit    sk [3] = '{1'b1, 1'b1, 1'b0};
  bit    armed = 1'b0;
  bit    just_rst = 1'b0;
  logic [31:0] obs_log [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [63:0] v, input int b);
    logic [63:0] one = 64'd1;
    if (v[b-1]) return v - (one << b);
    return v;
  endfunction

  // Reference decode from the format table using shifts/masks on the word
  function automatic void ref_dec(input logic [31:0] i, input int x,
                                  output logic [63:0] imm,
                                  output logic [2:0] t,
                                  output logic ill);
    logic [63:0] w = 64'(i);
    logic [63:0] v = 0;
    int op = int'(i[6:0]);
    int f3 = int'(i[14:12]);
    ill = (i[1:0] != 2'b11);
    case (op)
      'h37, 'h17: begin t = 0; v = sx(w & 64'hFFFFF000, 32); end
      'h03, 'h67: begin t = 1; v = sx((w >> 20) & 'hFFF, 12); end
      'h13: begin
        if (f3 == 1 || f3 == 5) begin
          t = 3;
          v = (w >> 20) & ((x == 64) ? 63 : 31);
          if (x == 32 && i[25]) ill = 1;
        end else begin
          t = 1; v = sx((w >> 20) & 'hFFF, 12);
        end
      end
      'h23: begin
        t = 2;
        v = sx((((w >> 25) & 127) << 5) | ((w >> 7) & 31), 12);
      end
      'h63: begin
        t = 4;
        v = sx((((w >> 8) & 15) << 1) | (((w >> 25) & 63) << 5)
             | (((w >> 7) & 1) << 11) | (((w >> 31) & 1) << 12), 13);
      end
      'h6F: begin
        t = 5;
        v = sx((((w >> 21) & 1023) << 1) | (((w >> 20) & 1) << 11)
             | (((w >> 12) & 255) << 12) | (((w >> 31) & 1) << 20), 21);
      end
      'h73: begin t = 6; v = (w >> 15) & 31; end
      default: begin t = 7; v = 0; ill = 1; end
    endcase
    imm = (x == 32) ? (v & 64'hFFFFFFFF) : v;
  endfunction

  function automatic logic exp_ir(input int d);
    if (sk[d]) return mcnt[d] < 2;
    return (mcnt[d] == 0) || out_ready;
  endfunction

  task automatic check_dut(input int d);
    logic [63:0] imm;
    logic [2:0]  t;
    logic        ill;
    logic [63:0] pm;
    chk($sformatf("in_ready%0d", d), 64'(a_ir[d]), 64'(exp_ir(d)));
    chk($sformatf("out_valid%0d", d), 64'(a_ov[d]), 64'(mcnt[d] > 0));
    if (mcnt[d] > 0) begin
      ref_dec(mq[d][0].instr, xl[d], imm, t, ill);
      pm = (xl[d] == 32) ? (mq[d][0].pc & 64'hFFFFFFFF) : mq[d][0].pc;
      chk($sformatf("imm%0d", d), a_imm[d], imm);
      chk($sformatf("type%0d", d), 64'(a_t[d]), 64'(t));
      chk($sformatf("illegal%0d", d), 64'(a_il[d]), 64'(ill));
      chk($sformatf("pc%0d", d), a_pc[d], pm);
      chk($sformatf("instr%0d", d), 64'(a_ins[d]),
          64'(mq[d][0].instr));
    end else if (just_rst) begin
      chk($sformatf("rst_imm%0d", d), a_imm[d], 64'd0);
      chk($sformatf("rst_type%0d", d), 64'(a_t[d]), 64'd0);
      chk($sformatf("rst_ill%0d", d), 64'(a_il[d]), 64'd0);
      chk($sformatf("rst_pc%0d", d), a_pc[d], 64'd0);
      chk($sformatf("rst_instr%0d", d), 64'(a_ins[d]), 64'd0);
    end
  endtask

  task automatic tick();
    bit    inf [3];
    bit    outf [3];
    item_t it;
    @(negedge clk);
    if (armed) for (int d = 0; d < 3; d++) check_dut(d);
    if (ov0 && out_ready && !rst) obs_log.push_back(ins0);
    it = '{instr: in_instr, pc: in_pc};
    for (int d = 0; d < 3; d++) begin
      inf[d]  = in_valid && exp_ir(d) && !rst;
      outf[d] = (mcnt[d] > 0) && out_ready;
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst) mcnt[d] = 0;
      else begin
        if (outf[d]) begin
          mq[d][0] = mq[d][1];
          mcnt[d]--;
        end
        if (inf[d]) begin
          mq[d][mcnt[d]] = it;
          mcnt[d]++;
        end
      end
    end
    just_rst = rst;
    if (rst) armed = 1'b1;
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = {$urandom, $urandom};
    tick();
  endtask

  logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h03, 7'h67, 7'h13,
                          7'h23, 7'h63, 7'h6F, 7'h73};
  logic [31:0] bp [4] = '{32'h00100093, 32'h00209113,
                          32'hFE000EE3, 32'h800000B7};

  initial begin
    logic [31:0] r;
    mcnt = '{0, 0, 0};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_out_valid", 64'(ov0), 64'd0);
    chk("reset_imm", 64'(imm0), 64'd0);
    chk("reset_in_ready", 64'(ir0), 64'd1);
    chk("reset_in_ready64", 64'(ir1), 64'd1);

    out_ready = 1'b1;
    send(32'hFFF00093);
    in_valid = 1'b0;
    chk("addi_valid", 64'(ov0), 64'd1);
    chk("addi_imm", 64'(imm0), 64'hFFFFFFFF);
    chk("addi_type", 64'(t0), 64'd1);
    chk("addi_ill", 64'(il0), 64'd0);

    send(32'h800000B7);
    chk("lui64_imm", imm1, 64'hFFFFFFFF80000000);
    chk("lui64_type", 64'(t1), 64'd0);
    send(32'hFE000EE3);
    chk("beq64_imm", imm1, 64'hFFFFFFFFFFFFFFFC);
    chk("beq64_type", 64'(t1), 64'd4);

    send(32'h03F09093);
    chk("slli64_imm", imm1, 64'd63);
    chk("slli64_type", 64'(t1), 64'd3);
    chk("slli64_ill", 64'(il1), 64'd0);
    chk("slli32_imm", 64'(imm0), 64'd31);
    chk("slli32_type", 64'(t0), 64'd3);
    chk("slli32_ill", 64'(il0), 64'd1);

    send(32'h00000000);
    chk("zero_type", 64'(t0), 64'd7);
    chk("zero_imm", 64'(imm0), 64'd0);
    chk("zero_ill", 64'(il0), 64'd1);
    send(32'h00000010);
    chk("lowbits_ill", 64'(il0), 64'd1);
    in_valid = 1'b0;
    tick();

    obs_log.delete();
    out_ready = 1'b0;
    send(bp[0]);
    send(bp[1]);
    chk("bp_ready_drop", 64'(ir0), 64'd0);
    send(bp[2]);
    out_ready = 1'b1;
    tick();
    chk("bp_ready_back", 64'(ir0), 64'd1);
    tick();
    send(bp[3]);
    in_valid = 1'b0;
    tick(); tick();
    chk("bp_count", 64'(obs_log.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < obs_log.size())
        chk($sformatf("bp_order%0d", k), 64'(obs_log[k]), 64'(bp[k]));

    out_ready = 1'b0;
    send($urandom);
    send($urandom);
    rst = 1'b1;
    send(32'h00100093);
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_valid", 64'(ov0), 64'd0);
    chk("mrst_imm", 64'(imm0), 64'd0);
    chk("mrst_instr", 64'(ins0), 64'd0);
    chk("mrst_pc", 64'(pc0), 64'd0);
    chk("mrst_ready", 64'(ir0), 64'd1);
    send(32'h00500113);
    in_valid = 1'b0;
    chk("mrst_after_valid", 64'(ov0), 64'd1);
    chk("mrst_after_instr", 64'(ins0), 64'h00500113);
    out_ready = 1'b1;
    tick();

    for (int n = 0; n < 600; n++) begin
      r = $urandom;
      if ($urandom_range(0, 9) < 9) r[6:0] = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 7) == 0) r[1:0] = 2'b00;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      in_instr  = r;
      in_pc     = {$urandom, $urandom};
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-decode pipeline stage between fetch and execute. Decodes the immediate format directly from the opcode, so no external immtype select is needed, and produces an XLEN-wide immediate for RV32 or RV64 builds. Also handles shift-amount and CSR zimm forms and flags unsupported encodings. A valid/ready handshake with an optional two-entry skid buffer gives full throughput under backpressure.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register, in_ready = !out_valid || out_ready.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of instruction
- out_valid  out  1  decoded result valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  extended immediate
- out_immtype  out  3  format code
- out_illegal  out  1  unsupported/illegal encoding
- out_pc  out  XLEN  pass-through PC
- out_instr  out  32  pass-through instruction

## Operation
- Transfer occurs on a cycle with valid && ready, on either side.
- Format codes, with opcode = instr[6:0]:
  - 000 U: LUI 0110111, AUIPC 0010111. Value = {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
  - 001 I: LOAD 0000011, JALR 1100111, and OP-IMM 0010011 with funct3 not 001/101. Sign-extends instr[31:20].
  - 010 S: STORE 0100011. Sign-extends {instr[31:25], instr[11:7]}.
  - 011 shift: OP-IMM with funct3 001/101. Zero-extends the shamt: instr[24:20] if XLEN=32, instr[25:20] if XLEN=64.
  - 100 B: BRANCH 1100011. Sign-extends {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - 101 J: JAL 1101111. Sign-extends {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - 110 CSR: SYSTEM 1110011. Zero-extends instr[19:15].
  - 111 other: imm = 0, illegal = 1.
- out_illegal is also 1 in these cases; the computed imm/type are kept:
  - instr[1:0] != 2'b11
  - shift format with XLEN=32 and instr[25] = 1
- The decode is combinational on the input side. Results, PC and instr are captured into the output register on transfer.
- SKID=1: state is {main, skid} entries.
  - Input accepted while main is occupied and not draining goes to skid.
  - in_ready = skid empty, registered.
  - When downstream accepts main, skid moves into main on the same edge.
  - Strict FIFO order; no loss and no duplication.
- SKID=0: a single entry. Accepting and draining in the same cycle is allowed.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 instruction/cycle while out_ready = 1.
- Reset values (cycle after rst sampled high):
  - out_valid = 0, out_imm = 0, out_immtype = 000, out_illegal = 0, out_pc = 0, out_instr = 0.
  - Skid empty; in_ready = 1 for SKID=1.
- Reset mid-operation discards main and skid contents. Inputs presented while rst is high are not accepted.
- While out_valid && !out_ready, all out_* fields hold stable.
- SKID=1 backpressure sequence:
  - First stalled accept fills skid.
  - in_ready drops the following cycle.
  - in_ready returns to 1 the cycle after skid drains into main.
- Simultaneous in-transfer and out-transfer with skid empty: new data goes straight to main and out_valid stays 1.

## Test plan
- Basic I-type: XLEN=32, in_instr 0xFFF00093 (addi x1,x0,-1). Next cycle: out_valid=1, out_imm 0xFFFFFFFF, type 001, illegal 0.
- RV64 U-type: XLEN=64, in_instr 0x800000B7 (lui). Expect out_imm 0xFFFFFFFF80000000, type 000. Also in_instr 0xFE000EE3 (beq -4): expect out_imm 0xFFFFFFFFFFFFFFFC, type 100.
- Shift width: in_instr 0x03F09093 (slli x1,x1,63).
  - XLEN=64: out_imm 63, type 011, illegal 0.
  - XLEN=32: out_imm 31, type 011, illegal 1.
- Illegal: in_instr 0x00000000 -> type 111, imm 0, illegal 1. in_instr 0x00000013 with bits[1:0] forced to 00 -> illegal 1.
- Backpressure, SKID=1: drive 4 back-to-back instrs A..D with out_ready low for 3 cycles.
  - A goes to main, B to skid; in_ready is 0 from the cycle after B.
  - After out_ready rises, the output order is exactly A, B, C, D.
  - Each appears for one accepted cycle with fields stable while stalled.
- Reset mid-stream: rst high for 1 cycle while main and skid are full. The next cycle has out_valid=0, all outputs 0, in_ready=1. A subsequent single instr appears one cycle after its accept.
